// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory and presents
// one in-order instruction per cycle, with stall hold and a one-bubble redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic               inst_valid,
    output logic               misalign
);

    typedef enum logic [1:0] {
        ST_BUBBLE = 2'b00,
        ST_RUN    = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fpc;
    logic [31:0] r_dpc;
    logic [31:0] r_hold;
    logic        r_misalign;

    logic        w_redirect;
    logic        w_advance;
    logic        w_capture;
    logic [31:0] w_fpc_inc;
    logic [31:0] w_target_aligned;

    assign imem_addr        = r_fpc[IMEM_AW+1:2];
    assign w_fpc_inc        = r_fpc + 32'd4;
    assign w_target_aligned = {branch_target[31:2], 2'b00};
    assign misalign         = r_misalign;

    // Classify the current cycle into redirect / advance / capture actions.
    always_comb begin
        w_redirect = 1'b0;
        w_advance  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_BUBBLE: begin
                w_advance = 1'b1;
            end
            ST_RUN, ST_HOLD: begin
                if (branch_taken) begin
                    w_redirect = 1'b1;
                end else if (stall) begin
                    w_capture = (r_state == ST_RUN);
                end else begin
                    w_advance = 1'b1;
                end
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; branch outranks stall, and the bubble ignores both.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BUBBLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_HOLD: begin
                if (branch_taken) begin
                    w_state_nxt = ST_BUBBLE;
                end else if (stall) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BUBBLE;
            end
        endcase
    end

    // Fetch/decode PCs, stalled-word capture and the misalign pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc      <= RESET_PC;
            r_dpc      <= RESET_PC;
            r_hold     <= NOP;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            if (w_redirect) begin
                r_fpc      <= w_target_aligned;
                r_misalign <= |branch_target[1:0];
            end else if (w_advance) begin
                r_dpc <= r_fpc;
                r_fpc <= w_fpc_inc;
            end else if (w_capture) begin
                // The memory word is only valid this cycle; keep it for HOLD.
                r_hold <= imem_rdata;
            end else begin
                r_fpc <= r_fpc;
            end
        end
    end

    // Output decode from the current state.
    always_comb begin
        pc_out   = r_dpc;
        pc_plus4 = r_dpc + 32'd4;
        case (r_state)
            ST_RUN: begin
                inst_valid  = 1'b1;
                instruction = imem_rdata;
            end
            ST_HOLD: begin
                inst_valid  = 1'b1;
                instruction = r_hold;
            end
            ST_BUBBLE: begin
                inst_valid  = 1'b0;
                instruction = NOP;
            end
            default: begin
                inst_valid  = 1'b0;
                instruction = NOP;
            end
        endcase
    end

endmodule
